// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: width, op codes, FSM states.
package div_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [4:0] CNT_INIT = 5'd31;
   localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } div_state_e;

   // Two's complement negation, used for magnitudes and sign correction.
   function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
      return ~x + 1'b1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor magnitude from
// the shifted partial remainder, keeping the difference only when no borrow.
module div_step
   import div_unit_pkg::*;
(
   input  logic [XLEN:0]   part_rem_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_bit_o
);

   logic [XLEN+1:0] sub;

   // The partial remainder carries one bit more than XLEN (a remainder with
   // its top bit set is shifted left), so the subtract runs one bit wider
   // still. The upper two bits are zero exactly when part >= divisor, because
   // the difference is then smaller than the divisor and fits in XLEN bits.
   always_comb begin
      sub     = {1'b0, part_rem_i} - {2'b00, dvs_i};
      q_bit_o = (sub[XLEN+1:XLEN] == 2'b00);
      rem_o   = q_bit_o ? sub[XLEN-1:0] : part_rem_i[XLEN-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Handshake: start_i is taken only in IDLE (flush_i has priority); busy_o is
// high while CALC or DONE; valid_o pulses one cycle with result_o, which then
// holds until the next completed operation.
module div_unit
   import div_unit_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [1:0]      div_op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   div_state_e      state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            rem_sel_q, rem_sel_d;   // 1: REM/REMU, 0: DIV/DIVU
   logic [XLEN-1:0] dvd_q, dvd_d;           // dividend shifting out, quotient shifting in
   logic [XLEN-1:0] dvs_q, dvs_d;           // divisor magnitude
   logic [XLEN-1:0] rem_q, rem_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            valid_q, valid_d;

   logic            is_signed, dvd_neg, dvs_neg, div_zero, ovf;
   logic [XLEN-1:0] dvd_mag, dvs_mag;
   logic [XLEN-1:0] step_rem;
   logic            step_q;

   div_step u_step (
      .part_rem_i ({rem_q, dvd_q[XLEN-1]}),
      .dvs_i      (dvs_q),
      .rem_o      (step_rem),
      .q_bit_o    (step_q)
   );

   // Operand classification and magnitude conversion for the capture cycle.
   always_comb begin
      is_signed = (div_op_i == OP_DIV) || (div_op_i == OP_REM);
      dvd_neg   = is_signed & dividend_i[XLEN-1];
      dvs_neg   = is_signed & divisor_i[XLEN-1];
      dvd_mag   = dvd_neg ? neg2c(dividend_i) : dividend_i;
      dvs_mag   = dvs_neg ? neg2c(divisor_i) : divisor_i;
      div_zero  = (divisor_i == '0);
      ovf       = is_signed && (dividend_i == XLEN_MIN) && (divisor_i == '1);
   end

   // Next-state and datapath update. Special cases preload the quotient and
   // remainder registers so DONE handles every operation the same way.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_sel_d = rem_sel_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      result_d  = result_q;
      valid_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rem_sel_d = div_op_i[1];
               cnt_d     = CNT_INIT;
               dvs_d     = dvs_mag;
               if (div_zero) begin
                  dvd_d   = '1;
                  rem_d   = dividend_i;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  state_d = S_DONE;
               end else if (ovf) begin
                  dvd_d   = XLEN_MIN;
                  rem_d   = '0;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  state_d = S_DONE;
               end else begin
                  dvd_d   = dvd_mag;
                  rem_d   = '0;
                  q_neg_d = dvd_neg ^ dvs_neg;
                  r_neg_d = dvd_neg;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            dvd_d = {dvd_q[XLEN-2:0], step_q};
            rem_d = step_rem;
            cnt_d = cnt_q - 5'd1;   // wraps back to 31 after the last step
            if (cnt_q == 5'd0) state_d = S_DONE;
         end
         S_DONE: begin
            if (rem_sel_q) result_d = r_neg_q ? neg2c(rem_q) : rem_q;
            else           result_d = q_neg_q ? neg2c(dvd_q) : dvd_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) begin
         state_d  = S_IDLE;
         cnt_d    = CNT_INIT;
         result_d = result_q;
         valid_d  = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= CNT_INIT;
         rem_sel_q <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         result_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_sel_q <= rem_sel_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
      end
   end

   assign busy_o   = (state_q != S_IDLE);
   assign valid_o  = valid_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results, latencies, busy
// window, ignored restart, flush and asynchronous reset.
module tb_div_unit;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  div_op_i = 2'b00;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        busy_o, valid_o;
   logic [31:0] result_o;

   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;

   div_unit dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .flush_i    (flush_i),
      .div_op_i   (div_op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation and follow it cycle by cycle (cycle k = k cycles
   // after the accepting edge). restart_k/flush_k inject a second start or a
   // flush in that cycle; 0 disables them. vcyc is -1 if valid_o never came.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int restart_k, input int flush_k,
                         output logic [31:0] res, output int vcyc, output int busy_n,
                         output logic busy_after_flush);
      @(negedge clk_i);
      start_i = 1'b1; div_op_i = op; dividend_i = a; divisor_i = b;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      vcyc = -1; busy_n = 0; res = 'x; busy_after_flush = 1'bx;
      for (int k = 1; k <= 60; k++) begin
         if (busy_o) busy_n++;
         if (busy_o && valid_o) overlap++;
         if (k == flush_k + 1 && flush_k != 0) busy_after_flush = busy_o;
         if (valid_o) begin
            vcyc = k;
            res  = result_o;
            break;
         end
         if (k == restart_k) begin
            start_i = 1'b1; div_op_i = 2'b00; dividend_i = 32'd7; divisor_i = 32'd1;
         end
         if (k == flush_k) flush_i = 1'b1;
         @(posedge clk_i); #1;
         start_i = 1'b0;
         flush_i = 1'b0;
      end
   endtask

   logic [31:0] res;
   int          vcyc, busy_n;
   logic        baf;

   initial begin
      // reset
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // DIVU 100 / 7
      run_op(2'b01, 32'd100, 32'd7, 0, 0, res, vcyc, busy_n, baf);
      check("divu_res", res, 32'd14);
      check("divu_lat", vcyc, 32'd34);
      check("divu_busy", busy_n, 32'd33);
      run_op(2'b11, 32'd100, 32'd7, 0, 0, res, vcyc, busy_n, baf);
      check("remu_res", res, 32'd2);

      // signed
      run_op(2'b00, -32'sd100, 32'd7, 0, 0, res, vcyc, busy_n, baf);
      check("div_neg", res, 32'hFFFF_FFF2);
      run_op(2'b10, -32'sd100, 32'd7, 0, 0, res, vcyc, busy_n, baf);
      check("rem_neg", res, 32'hFFFF_FFFE);
      run_op(2'b10, 32'd100, -32'sd7, 0, 0, res, vcyc, busy_n, baf);
      check("rem_negdvs", res, 32'd2);

      // divide by zero
      run_op(2'b00, 32'd5, 32'd0, 0, 0, res, vcyc, busy_n, baf);
      check("div0_res", res, 32'hFFFF_FFFF);
      check("div0_lat", vcyc, 32'd2);
      check("div0_busy", busy_n, 32'd1);
      run_op(2'b11, 32'd5, 32'd0, 0, 0, res, vcyc, busy_n, baf);
      check("remu0_res", res, 32'd5);

      // signed overflow
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, res, vcyc, busy_n, baf);
      check("ovf_div", res, 32'h8000_0000);
      check("ovf_lat", vcyc, 32'd2);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, res, vcyc, busy_n, baf);
      check("ovf_rem", res, 32'd0);

      // large unsigned divisor: remainder with its top bit set
      run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, res, vcyc, busy_n, baf);
      check("wide_divu", res, 32'd1);
      run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, res, vcyc, busy_n, baf);
      check("wide_remu", res, 32'h7FFF_FFFE);

      // second start while busy is ignored
      run_op(2'b01, 32'd1000, 32'd10, 10, 0, res, vcyc, busy_n, baf);
      check("ign_res", res, 32'd100);
      check("ign_lat", vcyc, 32'd34);

      // flush mid-calculation
      run_op(2'b01, 32'd50, 32'd5, 0, 20, res, vcyc, busy_n, baf);
      check("flush_novalid", vcyc, 32'hFFFF_FFFF);
      check("flush_idle", {31'b0, baf}, 32'd0);
      check("flush_busy", busy_n, 32'd20);
      check("flush_hold", result_o, 32'd100);

      // asynchronous reset mid-calculation
      @(negedge clk_i);
      start_i = 1'b1; div_op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd10;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_busy", {31'b0, busy_o}, 32'd0);
      check("arst_valid", {31'b0, valid_o}, 32'd0);
      check("arst_result", result_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0, 0, res, vcyc, busy_n, baf);
      check("post_rst_res", res, 32'hFFFF_FFFF);
      check("post_rst_lat", vcyc, 32'd34);

      check("busy_valid_excl", overlap, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
